// File: rtl/mode_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mode_select_ctrl
// Purpose  : Debounces four pushbuttons and runs the game-mode selection menu
//            (single / two-player / optional tutorial). It also issues
//            early-termination requests to the screen timer.
// Options  : TUTORIAL_MODE_EN - when defined, adds the tutorial menu entry,
//            the TUTORIAL state and its duration counter.
// Revision : 1.0 - initial release
// ============================================================================
module mode_select_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [31:0] TUTORIAL_CYCLES = 32'd2000000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  input  logic       btn_quit,
  input  logic       select_mode_screen,
  input  logic       end_of_game,
  input  logic       play_again,
  output logic       selected_a_mode,
  output logic       two_player_mode,
  output logic       tutorial_mode,
  output logic       end_game_early,
  output logic       end_tutorial,
  output logic [1:0] menu_cursor
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_CONFIRM = 2;
  localparam int BTN_QUIT    = 3;

`ifdef TUTORIAL_MODE_EN
  localparam logic [1:0] CURSOR_LAST = 2'd2;
`else
  localparam logic [1:0] CURSOR_LAST = 2'd1;
`endif

  logic [3:0] btn_raw;
  logic [3:0] press;

  assign btn_raw = {btn_quit, btn_confirm, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic             level_d;
    logic             press_r;
    logic [CNT_W-1:0] cnt;

    // Synchronize, debounce (any bounce restarts the count) and pulse on press
    always_ff @(posedge clock) begin
      if (reset) begin
        sync_a  <= 1'b0;
        sync_b  <= 1'b0;
        level   <= 1'b0;
        level_d <= 1'b0;
        press_r <= 1'b0;
        cnt     <= '0;
      end else begin
        sync_a  <= btn_raw[i];
        sync_b  <= sync_a;
        level_d <= level;
        press_r <= level & ~level_d;
        if (sync_b == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= sync_b;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[i] = press_r;
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MENU     = 3'd1,
    PLAY_1P  = 3'd2,
    PLAY_2P  = 3'd3,
`ifdef TUTORIAL_MODE_EN
    TUTORIAL = 3'd5,
`endif
    DONE     = 3'd4
  } state_t;

  state_t state;

`ifdef TUTORIAL_MODE_EN
  logic        tutorial_mode_r;
  logic        end_tutorial_r;
  logic [31:0] tut_cnt;

  assign tutorial_mode = tutorial_mode_r;
  assign end_tutorial  = end_tutorial_r;
`else
  assign tutorial_mode = 1'b0;
  assign end_tutorial  = 1'b0;
`endif

  // Mode-selection FSM; every output is registered alongside the state
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      menu_cursor     <= 2'd0;
      selected_a_mode <= 1'b0;
      two_player_mode <= 1'b0;
      end_game_early  <= 1'b0;
`ifdef TUTORIAL_MODE_EN
      tutorial_mode_r <= 1'b0;
      end_tutorial_r  <= 1'b0;
      tut_cnt         <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (select_mode_screen) state <= MENU;
        end
        MENU: begin
          // confirm beats up, up beats down; losers are simply dropped
          if (press[BTN_CONFIRM]) begin
            case (menu_cursor)
              2'd0: begin
                selected_a_mode <= 1'b1;
                state           <= PLAY_1P;
              end
              2'd1: begin
                two_player_mode <= 1'b1;
                state           <= PLAY_2P;
              end
`ifdef TUTORIAL_MODE_EN
              2'd2: begin
                selected_a_mode <= 1'b1;
                tutorial_mode_r <= 1'b1;
                tut_cnt         <= 32'd0;
                state           <= TUTORIAL;
              end
`endif
              default: ;
            endcase
          end else if (press[BTN_UP]) begin
            menu_cursor <= (menu_cursor == CURSOR_LAST) ? 2'd0 : menu_cursor + 2'd1;
          end else if (press[BTN_DOWN]) begin
            menu_cursor <= (menu_cursor == 2'd0) ? CURSOR_LAST : menu_cursor - 2'd1;
          end
        end
        PLAY_1P, PLAY_2P: begin
          if (press[BTN_QUIT]) begin
            end_game_early <= 1'b1;
            state          <= DONE;
          end else if (end_of_game) begin
            state <= DONE;
          end
        end
`ifdef TUTORIAL_MODE_EN
        TUTORIAL: begin
          // quit and timeout together still yield a single end request
          if (press[BTN_QUIT] || (tut_cnt == TUTORIAL_CYCLES - 32'd1)) begin
            end_tutorial_r <= 1'b1;
            state          <= DONE;
          end else begin
            tut_cnt <= tut_cnt + 32'd1;
          end
        end
`endif
        DONE: begin
          if (play_again) begin
            end_game_early <= 1'b0;
`ifdef TUTORIAL_MODE_EN
            end_tutorial_r <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mode_select_ctrl.md
MODE_SELECT_CTRL -- requirements
Module: mode_select_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, stable-input cycles required to accept a button level change.
REQ-002 Parameter: TUTORIAL_CYCLES, default 2000000000, tutorial duration in cycles; 32-bit.
REQ-003 Ports: clock  in  1  single clock; all logic on posedge clock.
REQ-004 Ports: reset  in  1  synchronous, active-high reset.
REQ-005 Ports: btn_up, btn_down, btn_confirm, btn_quit  in  1 each  raw, asynchronous, active-high pushbuttons.
REQ-006 Ports: select_mode_screen, end_of_game, play_again  in  1 each  phase levels from the screen timer.
REQ-007 Ports: selected_a_mode, two_player_mode, tutorial_mode  out  1 each  chosen game mode, level.
REQ-008 Ports: end_game_early, end_tutorial  out  1 each  early-termination requests to the screen timer, level.
REQ-009 Ports: menu_cursor  out  2  highlighted menu entry (0 = single, 1 = two-player, 2 = tutorial).

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose debounced level updates only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-011 A one-cycle press pulse SHALL be generated on each 0->1 transition of a debounced level; releases generate nothing.
REQ-012 Button edge to press pulse latency SHALL be exactly 2 + DEBOUNCE_CYCLES + 1 cycles for a clean edge.
REQ-013 FSM states SHALL be IDLE, MENU, PLAY_1P, PLAY_2P, TUTORIAL, DONE.
REQ-014 IDLE -> MENU when select_mode_screen = 1; press pulses in IDLE SHALL be ignored.
REQ-015 In MENU, up SHALL increment menu_cursor and down SHALL decrement it, wrapping from last entry to 0 and from 0 to last entry.
REQ-016 Same-cycle press priority in MENU SHALL be confirm > up > down; lower-priority pulses that cycle are discarded.
REQ-017 Confirm in MENU, registered the following cycle: cursor 0 -> selected_a_mode = 1, PLAY_1P; cursor 1 -> two_player_mode = 1, PLAY_2P; cursor 2 -> selected_a_mode = 1 and tutorial_mode = 1, TUTORIAL.
REQ-018 Mode outputs SHALL stay asserted from confirm until reset; at most one of PLAY_1P and PLAY_2P is ever entered per reset.
REQ-019 In PLAY_1P/PLAY_2P, quit SHALL set end_game_early = 1 and enter DONE; end_of_game = 1 SHALL enter DONE without setting end_game_early.
REQ-020 In TUTORIAL, a 32-bit counter SHALL start at 0 on entry and increment each cycle; when it equals TUTORIAL_CYCLES - 1, or on quit, end_tutorial SHALL be set to 1 and the FSM SHALL enter DONE.
REQ-021 Quit and timeout in the same cycle SHALL produce one end_tutorial assertion; no other effect.
REQ-022 end_game_early and end_tutorial SHALL hold at 1 until play_again = 1, then clear on the next cycle; DONE is terminal until reset.
REQ-023 Up/down/confirm pulses outside MENU, and quit outside play/tutorial states, SHALL be ignored.

Reset
REQ-024 While reset = 1 on a clock edge: FSM = IDLE, menu_cursor = 0, all 1-bit outputs = 0, tutorial counter = 0, synchronizers, debounced levels and debounce counters = 0.
REQ-025 Reset asserted mid-debounce, mid-menu or mid-tutorial SHALL abandon all progress; a button held through reset release SHALL produce a press pulse only after a full debounce period.

Configuration
REQ-026 Macro TUTORIAL_MODE_EN: when defined, the menu has 3 entries (wrap 2<->0) and TUTORIAL is implemented per REQ-020..022.
REQ-027 Without TUTORIAL_MODE_EN: menu has 2 entries (wrap 1<->0), TUTORIAL state and counter are absent, and tutorial_mode and end_tutorial are tied to 0.

Verification (DEBOUNCE_CYCLES = 4, TUTORIAL_CYCLES = 20)
REQ-028 Bounce: btn_up toggles 1,0,1 over 3 cycles then stays 1 in MENU -> exactly one cursor increment, 0 -> 1.
REQ-029 Wrap: in MENU with cursor 0, one down press -> cursor 2 (macro defined) / 1 (macro undefined); then one up press -> 0.
REQ-030 Priority: confirm and up pressed in the same cycle with cursor 1 -> two_player_mode = 1, cursor stays 1, state PLAY_2P.
REQ-031 Early end: PLAY_1P, quit pressed -> end_game_early = 1 held; play_again = 1 -> end_game_early = 0 one cycle later.
REQ-032 Tutorial timeout: confirm at cursor 2 -> selected_a_mode = 1, tutorial_mode = 1; end_tutorial rises exactly 20 cycles after TUTORIAL entry.
REQ-033 Reset mid-tutorial at cycle 10 -> all outputs 0, state IDLE; a re-entered tutorial restarts the full 20-cycle count.
